// File: rtl/fir_output_stage.sv
// FIR output stage: saturates the accumulator sum to OUT_BITS, buffers it in a
// DEPTH-entry FIFO with ready/valid output; FIR_OUT_STATS_EN adds event counters.
`timescale 1ns/1ps
module fir_output_stage #(
   parameter int IN_BITS  = 41,
   parameter int OUT_BITS = 16,
   parameter int DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic signed [IN_BITS-1:0]    in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_BITS-1:0]          out_data,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         overflow,
   output logic                         sat_flag,
`ifdef FIR_OUT_STATS_EN
   output logic [15:0]                  sat_count,
   output logic [15:0]                  drop_count,
`endif
   input  logic                         clear_flags
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic signed [IN_BITS-1:0] SAT_MAX = {{(IN_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [IN_BITS-1:0] SAT_MIN = {{(IN_BITS-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
   localparam logic [OUT_BITS-1:0] WORD_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
   localparam logic [OUT_BITS-1:0] WORD_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

   // Returns {clipped, saturated word}; plain truncation when the sample fits.
   function automatic logic [OUT_BITS:0] saturate(input logic signed [IN_BITS-1:0] x);
      logic [OUT_BITS:0] r;
      if (x > SAT_MAX) begin
         r = {1'b1, WORD_MAX};
      end else if (x < SAT_MIN) begin
         r = {1'b1, WORD_MIN};
      end else begin
         r = {1'b0, x[OUT_BITS-1:0]};
      end
      return r;
   endfunction

   logic [OUT_BITS-1:0] mem_r [DEPTH];
   logic [PW-1:0]       wr_ptr_r;
   logic [PW-1:0]       rd_ptr_r;
   logic [LW-1:0]       level_r;
   logic                out_valid_r;
   logic                overflow_r;
   logic                sat_flag_r;

   logic [OUT_BITS-1:0] sat_word_s;
   logic                clip_s;
   logic                pop_s;
   logic                push_s;
   logic                drop_s;
   logic                sat_evt_s;
   logic [LW-1:0]       level_next_s;

   // Handshake decode and occupancy update; a pop frees a slot even at full.
   always_comb begin
      {clip_s, sat_word_s} = saturate(in_data);
      pop_s     = out_valid_r && out_ready;
      push_s    = in_valid && ((level_r != FULL_LVL) || pop_s);
      drop_s    = in_valid && !push_s;
      sat_evt_s = in_valid && clip_s;
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + LW'(1);
         2'b01:   level_next_s = level_r - LW'(1);
         default: level_next_s = level_r;
      endcase
   end

   // FIFO storage; cleared on reset so the head word reads 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {OUT_BITS{1'b0}};
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= sat_word_s;
      end
   end

   // Pointers, occupancy and the registered valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         level_r     <= {LW{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         level_r     <= level_next_s;
         out_valid_r <= (level_next_s != {LW{1'b0}});
      end
   end

   // Sticky flags: a set event in the clear cycle wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r <= 1'b0;
         sat_flag_r <= 1'b0;
      end else begin
         if (drop_s)           overflow_r <= 1'b1;
         else if (clear_flags) overflow_r <= 1'b0;
         if (sat_evt_s)        sat_flag_r <= 1'b1;
         else if (clear_flags) sat_flag_r <= 1'b0;
      end
   end

`ifdef FIR_OUT_STATS_EN
   logic [15:0] sat_count_r;
   logic [15:0] drop_count_r;

   // Saturating event counters; an event in the clear cycle leaves 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_count_r  <= 16'h0000;
         drop_count_r <= 16'h0000;
      end else if (clear_flags) begin
         sat_count_r  <= {15'h0000, sat_evt_s};
         drop_count_r <= {15'h0000, drop_s};
      end else begin
         if (sat_evt_s && (sat_count_r != 16'hFFFF)) sat_count_r  <= sat_count_r + 16'h0001;
         if (drop_s && (drop_count_r != 16'hFFFF))   drop_count_r <= drop_count_r + 16'h0001;
      end
   end

   assign sat_count  = sat_count_r;
   assign drop_count = drop_count_r;
`endif

   assign out_valid = out_valid_r;
   assign out_data  = mem_r[rd_ptr_r];
   assign level     = level_r;
   assign overflow  = overflow_r;
   assign sat_flag  = sat_flag_r;

endmodule

// File: tb/tb_fir_output_stage.sv
// Self-checking bench for fir_output_stage: table-driven saturation vectors plus
// FIFO fill/drain, full-throughput, flag-clear and async-reset sequences.
`timescale 1ns/1ps
module tb_fir_output_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [40:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  level;
   logic        overflow;
   logic        sat_flag;
   logic        clear_flags;
`ifdef FIR_OUT_STATS_EN
   logic [15:0] sat_count;
   logic [15:0] drop_count;
`endif

   fir_output_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .overflow(overflow), .sat_flag(sat_flag),
`ifdef FIR_OUT_STATS_EN
      .sat_count(sat_count), .drop_count(drop_count),
`endif
      .clear_flags(clear_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint      data;
      logic [15:0] word;
      bit          clip;
   } vec_t;

   int nchecks = 0;
   int nerrors = 0;

   logic [15:0] q[$];
   int m_level;
   bit m_ovf, m_sat;
   int m_satc, m_dropc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_level = 0; m_ovf = 0; m_sat = 0; m_satc = 0; m_dropc = 0;
   endtask

   task automatic check_regs();
      chk("level", 64'(level), 64'(m_level));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("sat_flag", 64'(sat_flag), 64'(m_sat));
`ifdef FIR_OUT_STATS_EN
      chk("sat_count", 64'(sat_count), 64'(m_satc));
      chk("drop_count", 64'(drop_count), 64'(m_dropc));
`endif
   endtask

   // One clock: drive, check head, update model, clock, check registers.
   task automatic cycle(input bit v, input longint d, input logic [15:0] w,
                        input bit clip, input bit r, input bit clr);
      bit pop, push, drop, sev;
      logic [15:0] tmp;
      in_valid = v; in_data = d[40:0]; out_ready = r; clear_flags = clr;
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_level > 0));
      if (m_level > 0) chk("head", 64'(out_data), 64'(q[0]));
      pop  = (m_level > 0) && r;
      push = v && ((m_level < 8) || pop);
      drop = v && !push;
      sev  = v && clip;
      if (pop) tmp = q.pop_front();
      if (push) q.push_back(w);
      m_level = m_level + int'(push) - int'(pop);
      if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
      if (sev) m_sat = 1; else if (clr) m_sat = 0;
      if (clr) begin
         m_satc = int'(sev); m_dropc = int'(drop);
      end else begin
         if (sev && m_satc < 65535) m_satc++;
         if (drop && m_dropc < 65535) m_dropc++;
      end
      @(posedge clk); #1;
      check_regs();
      in_valid = 0; clear_flags = 0;
   endtask

   task automatic idle(input bit r);
      cycle(0, 0, 16'h0000, 0, r, 0);
   endtask

   task automatic sample(input longint d, input bit r);
      cycle(1, d, d[15:0], 0, r, 0);
   endtask

   initial begin
      vec_t vecs[9];
      vecs[0] = '{40000,          16'h7FFF, 1'b1};
      vecs[1] = '{-40000,         16'h8000, 1'b1};
      vecs[2] = '{-32768,         16'h8000, 1'b0};
      vecs[3] = '{32767,          16'h7FFF, 1'b0};
      vecs[4] = '{32768,          16'h7FFF, 1'b1};
      vecs[5] = '{-32769,         16'h8000, 1'b1};
      vecs[6] = '{-1,             16'hFFFF, 1'b0};
      vecs[7] = '{64'h0FFFFFFFFFF, 16'h7FFF, 1'b1};
      vecs[8] = '{-64'sd1099511627776, 16'h8000, 1'b1};

      rst = 1; in_valid = 0; in_data = '0; out_ready = 0; clear_flags = 0;
      model_reset();
      #1;
      chk("rst_out_data", 64'(out_data), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      check_regs();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      @(posedge clk); #1;

      // Basic latency
      sample(64'h1234, 1);
      idle(1);
      idle(1);

      // Saturation table, streamed with consumer ready
      for (int i = 0; i < 9; i++) cycle(1, vecs[i].data, vecs[i].word, vecs[i].clip, 1, 0);
      repeat (2) idle(1);
      cycle(0, 0, 16'h0000, 0, 1, 1);

      // Back-pressure: 10 samples into 8 entries, then drain
      for (int i = 1; i <= 10; i++) sample(i, 0);
      repeat (3) idle(0);
      repeat (9) idle(1);
      cycle(0, 0, 16'h0000, 0, 1, 1);

      // Full with simultaneous push/pop
      for (int i = 0; i < 8; i++) sample(100 + i, 0);
      for (int i = 0; i < 5; i++) sample(200 + i, 1);
      repeat (9) idle(1);

      // Clear coinciding with a clipping sample, then clear alone
      cycle(1, 50000, 16'h7FFF, 1, 1, 1);
      cycle(0, 0, 16'h0000, 0, 1, 1);
      idle(1);

      // Async reset mid-stream with level 5
      cycle(1, 40000, 16'h7FFF, 1, 0, 0);
      for (int i = 1; i < 5; i++) sample(300 + i, 0);
      #3 rst = 1;
      #1;
      model_reset();
      chk("arst_out_valid", 64'(out_valid), 64'h0);
      chk("arst_out_data", 64'(out_data), 64'h0);
      check_regs();
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      sample(16'h0ABC, 1);
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
